multicycle_chunk_adder: RTL and testbench



---
 rtl/multicycle_chunk_adder.sv | 141 ++++++++++++++
 tb/tb_multicycle_chunk_adder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_chunk_adder.sv
// multicycle_chunk_adder
// Adds two WIDTH-bit operands CHUNK bits per clock through a registered carry,
// so a result takes N = WIDTH/CHUNK cycles. Valid/ready handshake on both sides;
// produces sum, carry-out and signed overflow.
// Optional build macro SUBTRACT_EN: adds a 'sub' input; when set at acceptance
// the block computes A-B (B inverted, carry seeded with 1, cin ignored).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for operands, in_ready=1
// ST_RUN   | rippling one chunk per clock, counter selects the chunk
// ST_DONE  | result held on outputs with out_valid=1 until out_ready
module multicycle_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_bus,
  input  logic [WIDTH-1:0] B_bus,
  input  logic             cin,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S_bus,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Mask covering one chunk at bit 0; shifted into place when writing the sum.
  localparam logic [WIDTH-1:0] CMASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      sh;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;
  logic             msb_cin;

  // Select the active chunk and add it with the running carry.
  assign sh         = 32'(cnt_q) * 32'(CHUNK);
  assign a_chunk    = CHUNK'(a_q >> sh);
  assign b_chunk    = CHUNK'(b_q >> sh);
  assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  assign last_chunk = (cnt_q == CW'(N - 1));
  // On the last chunk its top bit is the MSB; the carry into it is recovered
  // from the sum bit (s = a ^ b ^ c).
  assign msb_cin    = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ chunk_sum[CHUNK-1];

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d = A_bus;
`ifdef SUBTRACT_EN
          b_d     = sub ? ~B_bus : B_bus;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = B_bus;
          carry_d = cin;
`endif
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d     = (s_q & ~(CMASK << sh)) | (WIDTH'(chunk_sum[CHUNK-1:0]) << sh);
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last_chunk) begin
          cout_d  = chunk_sum[CHUNK];
          ovf_d   = msb_cin ^ chunk_sum[CHUNK];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign S_bus     = s_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Bench for multicycle_chunk_adder: an 8/2 instance checked against an
// arithmetic model on every cycle, plus 4/1 and 4/4 instances for latency.
module tb_multicycle_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       iv8, ir8, cin8, sub8, ov8, ordy8, co8, of8;
  logic [7:0] a8, b8, s8;
  logic       iv41, ir41, cin41, ov41, co41, of41;
  logic [3:0] a41, b41, s41;
  logic       iv44, ir44, cin44, ov44, co44, of44;
  logic [3:0] a44, b44, s44;
  logic       ordy4, sub4;

  multicycle_chunk_adder #(.WIDTH(8), .CHUNK(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .A_bus(a8), .B_bus(b8), .cin(cin8),
`ifdef SUBTRACT_EN
    .sub(sub8),
`endif
    .out_valid(ov8), .out_ready(ordy8), .S_bus(s8), .cout(co8), .overflow(of8));

  multicycle_chunk_adder #(.WIDTH(4), .CHUNK(1)) u41 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv41), .in_ready(ir41),
    .A_bus(a41), .B_bus(b41), .cin(cin41),
`ifdef SUBTRACT_EN
    .sub(sub4),
`endif
    .out_valid(ov41), .out_ready(ordy4), .S_bus(s41), .cout(co41), .overflow(of41));

  multicycle_chunk_adder #(.WIDTH(4), .CHUNK(4)) u44 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv44), .in_ready(ir44),
    .A_bus(a44), .B_bus(b44), .cin(cin44),
`ifdef SUBTRACT_EN
    .sub(sub4),
`endif
    .out_valid(ov44), .out_ready(ordy4), .S_bus(s44), .cout(co44), .overflow(of44));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: {overflow, cout, sum} from plain wide arithmetic; overflow is
  // "operands share a sign and the result sign differs".
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic s);
    logic [7:0] bb;
    logic       cc;
    logic [8:0] t;
    logic       ov;
    bb = s ? ~b : b;
    cc = s ? 1'b1 : c;
    t  = {1'b0, a} + {1'b0, bb} + {8'd0, cc};
    ov = (a[7] == bb[7]) && (t[7] != a[7]);
    return {ov, t};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] t;
    logic       ov;
    t  = {1'b0, a} + {1'b0, b} + {4'd0, c};
    ov = (a[3] == b[3]) && (t[3] != a[3]);
    return {ov, t};
  endfunction

  logic       exp_busy = 1'b0;
  logic       cmp_en   = 1'b0;
  logic [7:0] m_s;
  logic       m_co, m_of;

  // Per-cycle comparison of the 8/2 instance against the model.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("in_ready vs model", {31'd0, ir8}, {31'd0, !exp_busy});
      if (!exp_busy) chk("out_valid while idle", {31'd0, ov8}, 32'd0);
      if (ov8) begin
        chk("S vs model", {24'd0, s8}, {24'd0, m_s});
        chk("cout vs model", {31'd0, co8}, {31'd0, m_co});
        chk("overflow vs model", {31'd0, of8}, {31'd0, m_of});
      end
    end
  end

  task automatic txn8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic s, input logic [7:0] es,
                      input logic eco, input logic eof, input int hold);
    logic [9:0] m;
    int lat;
    m = model8(a, b, c, s);
    chk({name, " model pin"}, {22'd0, m}, {22'd0, eof, eco, es});
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; sub8 = s; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; exp_busy = 1'b1;
    m_s = m[7:0]; m_co = m[8]; m_of = m[9];
    a8 = ~a; b8 = 8'h5A; cin8 = ~c; sub8 = ~s;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, lat, 32'd4);
    chk({name, " S"}, {24'd0, s8}, {24'd0, es});
    chk({name, " cout"}, {31'd0, co8}, {31'd0, eco});
    chk({name, " overflow"}, {31'd0, of8}, {31'd0, eof});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      iv8 = 1'b1; a8 = 8'hC3 + 8'(i); b8 = 8'h3C;
      @(posedge clk); #1;
      chk({name, " held valid"}, {31'd0, ov8}, 32'd1);
      chk({name, " held in_ready"}, {31'd0, ir8}, 32'd0);
      chk({name, " held S"}, {24'd0, s8}, {24'd0, es});
    end
    @(negedge clk);
    iv8 = 1'b0; ordy8 = 1'b1;
    @(posedge clk); #1;
    ordy8 = 1'b0; exp_busy = 1'b0;
    chk({name, " consumed valid"}, {31'd0, ov8}, 32'd0);
    chk({name, " consumed in_ready"}, {31'd0, ir8}, 32'd1);
  endtask

  task automatic run4(input string name, input int which, input logic [3:0] a,
                      input logic [3:0] b, input logic c, input logic [3:0] es,
                      input logic eco, input logic eof, input int elat);
    logic [5:0] m;
    int lat;
    logic v;
    m = model4(a, b, c);
    chk({name, " model pin"}, {26'd0, m}, {26'd0, eof, eco, es});
    @(negedge clk);
    if (which == 0) begin a41 = a; b41 = b; cin41 = c; iv41 = 1'b1; end
    else            begin a44 = a; b44 = b; cin44 = c; iv44 = 1'b1; end
    @(posedge clk); #1;
    iv41 = 1'b0; iv44 = 1'b0;
    a41 = 4'hF; b41 = 4'hF; a44 = 4'hF; b44 = 4'hF;
    lat = 0;
    v = (which == 0) ? ov41 : ov44;
    while (!v && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      v = (which == 0) ? ov41 : ov44;
    end
    chk({name, " latency"}, lat, elat);
    if (which == 0) begin
      chk({name, " S"}, {28'd0, s41}, {28'd0, es});
      chk({name, " cout"}, {31'd0, co41}, {31'd0, eco});
      chk({name, " overflow"}, {31'd0, of41}, {31'd0, eof});
    end else begin
      chk({name, " S"}, {28'd0, s44}, {28'd0, es});
      chk({name, " cout"}, {31'd0, co44}, {31'd0, eco});
      chk({name, " overflow"}, {31'd0, of44}, {31'd0, eof});
    end
    @(posedge clk); #1;
    chk({name, " back to idle"}, {31'd0, (which == 0) ? ir41 : ir44}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; ordy8 = 0;
    iv41 = 0; a41 = 0; b41 = 0; cin41 = 0;
    iv44 = 0; a44 = 0; b44 = 0; cin44 = 0;
    ordy4 = 1'b1; sub4 = 1'b0;
    #12;
    chk("reset in_ready", {31'd0, ir8}, 32'd1);
    chk("reset out_valid", {31'd0, ov8}, 32'd0);
    chk("reset S", {24'd0, s8}, 32'd0);
    chk("reset cout", {31'd0, co8}, 32'd0);
    chk("reset overflow", {31'd0, of8}, 32'd0);
    chk("reset in_ready 4/1", {31'd0, ir41}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    txn8("1+1", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 0);
    txn8("FF+1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    txn8("7F+1", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    txn8("AA+55+1 backpressure", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5);
    txn8("80+80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    txn8("7F+1 again", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);

    // Reset two cycles into a computation.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; exp_busy = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    exp_busy = 1'b0;
    chk("midrun reset in_ready", {31'd0, ir8}, 32'd1);
    chk("midrun reset out_valid", {31'd0, ov8}, 32'd0);
    chk("midrun reset S", {24'd0, s8}, 32'd0);
    chk("midrun reset cout", {31'd0, co8}, 32'd0);
    chk("midrun reset overflow", {31'd0, of8}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no valid in reset", {31'd0, ov8}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no valid after reset", {31'd0, ov8}, 32'd0);
    end
    txn8("10+20", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 0);

`ifdef SUBTRACT_EN
    txn8("5-7", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    txn8("80-1", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
`endif

    run4("w4c1 3+3", 0, 4'h3, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0, 4);
    run4("w4c1 7+1", 0, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 4);
    run4("w4c4 2+1+1", 1, 4'h2, 4'h1, 1'b1, 4'h4, 1'b0, 1'b0, 1);
    run4("w4c4 F+1", 1, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
